// File: rtl/regs_wb_sched_pkg.sv
// Shared constants and FSM encoding for the register-file write-port scheduler.
package regs_wb_sched_pkg;

  localparam logic [31:0] ZeroWord = 32'h0;
  localparam logic [4:0]  ZeroReg  = 5'h0;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hold_state_t;

endpackage

// File: rtl/regs_wb_sched_wb_scoreboard.sv
// Outstanding-load scoreboard: one pending bit per register, x0 never tracked,
// plus the three-port hazard lookup used to stall ID.
module wb_scoreboard
  import regs_wb_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  output logic [31:0] pending,
  output logic        hazard
);

  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] pending_next;

  // Next scoreboard value; the set is applied after the clear so a newly issued
  // load to the register being written back stays outstanding.
  always_comb begin
    set_mask = ZeroWord;
    clr_mask = ZeroWord;
    if (set_en && (set_idx != ZeroReg)) set_mask[set_idx] = 1'b1;
    if (clr_en && (clr_idx != ZeroReg)) clr_mask[clr_idx] = 1'b1;
    pending_next    = (pending & ~clr_mask) | set_mask;
    pending_next[0] = 1'b0;
  end

  // Pending register; reset drops every outstanding load.
  always_ff @(posedge clk) begin
    if (!rst) pending <= ZeroWord;
    else      pending <= pending_next;
  end

  // Hazard if any ID operand or the destination still awaits load data.
  always_comb begin
    hazard = 1'b0;
    if ((rs1 != ZeroReg) && pending[rs1]) hazard = 1'b1;
    if ((rs2 != ZeroReg) && pending[rs2]) hazard = 1'b1;
    if ((rd  != ZeroReg) && pending[rd])  hazard = 1'b1;
  end

endmodule

// File: rtl/regs_wb_sched.sv
// Write-port scheduler: arbitrates the register-file write port between EX
// (priority) and returning LSU loads, tracks outstanding loads and holds EX
// off when the LSU has been blocked for STARVE_MAX consecutive cycles.
module regs_wb_sched
  import regs_wb_sched_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_wen_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        ld_issue_i,
  input  logic [4:0]  ld_issue_rd_i,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  output logic        stall_o,
  output logic        ex_hold_o,
  output logic        reg_wen_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic [31:0] pending_o
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic        grant;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  blk_cnt;
  logic [3:0]  blk_next;
  hold_state_t state;
  hold_state_t state_next;
  logic [31:0] pending;
  logic        hazard;

  // Port arbitration: EX wins, otherwise an LSU load is granted the port.
  always_comb begin
    grant = 1'b0;
    wen   = 1'b0;
    waddr = ZeroReg;
    wdata = ZeroWord;
    if (ex_wen_i) begin
      wen   = 1'b1;
      waddr = ex_waddr_i;
      wdata = ex_wdata_i;
    end else if (lsu_valid_i) begin
      grant = 1'b1;
      wen   = 1'b1;
      waddr = lsu_rd_i;
      wdata = lsu_data_i;
    end
  end

  // Consecutive blocked-LSU counter, saturating at the starvation limit.
  always_comb begin
    blk_next = blk_cnt;
    if (!lsu_valid_i || grant)   blk_next = 4'd0;
    else if (blk_cnt != StarveMax) blk_next = blk_cnt + 4'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst) blk_cnt <= 4'd0;
    else      blk_cnt <= blk_next;
  end

  // Hold FSM next state; entering HOLD on the edge where the counter reaches
  // the limit makes ex_hold_o visible in the following (5th blocked) cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (blk_next == StarveMax) state_next = HOLD;
      HOLD:    if (grant) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  wb_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (ld_issue_i),
    .set_idx (ld_issue_rd_i),
    .clr_en  (grant),
    .clr_idx (lsu_rd_i),
    .rs1     (id_rs1_i),
    .rs2     (id_rs2_i),
    .rd      (id_rd_i),
    .pending (pending),
    .hazard  (hazard)
  );

  assign reg_wen_o   = rst & wen;
  assign reg_waddr_o = rst ? waddr : ZeroReg;
  assign reg_wdata_o = rst ? wdata : ZeroWord;
  assign lsu_ready_o = rst & grant;
  assign stall_o     = rst & hazard;
  assign ex_hold_o   = rst & (state == HOLD);
  assign pending_o   = rst ? pending : ZeroWord;

endmodule

// File: tb/tb_regs_wb_sched.sv
// Self-checking bench for regs_wb_sched: a behavioural model predicts each
// cycle's outputs, which are queued at drive time and popped at the sample.
module tb_regs_wb_sched;

  localparam int StarveMax = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_wen_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        ld_issue_i;
  logic [4:0]  ld_issue_rd_i;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic        lsu_ready_o;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic [4:0]  id_rd_i;
  logic        stall_o;
  logic        ex_hold_o;
  logic        reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic [31:0] pending_o;

  regs_wb_sched #(.STARVE_MAX(StarveMax)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_wen_i      (ex_wen_i),
    .ex_waddr_i    (ex_waddr_i),
    .ex_wdata_i    (ex_wdata_i),
    .ld_issue_i    (ld_issue_i),
    .ld_issue_rd_i (ld_issue_rd_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_rd_i      (lsu_rd_i),
    .lsu_data_i    (lsu_data_i),
    .lsu_ready_o   (lsu_ready_o),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rd_i       (id_rd_i),
    .stall_o       (stall_o),
    .ex_hold_o     (ex_hold_o),
    .reg_wen_o     (reg_wen_o),
    .reg_waddr_o   (reg_waddr_o),
    .reg_wdata_o   (reg_wdata_o),
    .pending_o     (pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ready;
    logic        stall;
    logic        hold;
    logic [31:0] pend;
  } exp_t;

  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] m_pend = 32'h0;
  int          m_run = 0;
  logic        m_hold = 1'b0;
  logic        m_blocked = 1'b0;

  logic        obs_wen, obs_ready, obs_stall, obs_hold;
  logic [4:0]  obs_addr;
  logic [31:0] obs_data, obs_pend;

  // Count one comparison and report it if observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, observed, expected);
    end
  endtask

  task automatic clearInputs();
    ex_wen_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    ld_issue_i = 0; ld_issue_rd_i = 0;
    lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
    id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
  endtask

  // Run one clock cycle with the inputs currently driven: predict and queue
  // the outputs, compare them mid-cycle, then advance the model at the edge.
  task automatic applyStimulus();
    exp_t e;
    exp_t got;
    logic g;
    g = !ex_wen_i && lsu_valid_i;
    e.wen = 0; e.addr = 0; e.data = 0; e.ready = 0; e.stall = 0; e.hold = 0; e.pend = 0;
    if (rst) begin
      e.wen   = ex_wen_i || lsu_valid_i;
      e.addr  = ex_wen_i ? ex_waddr_i : (lsu_valid_i ? lsu_rd_i : 5'd0);
      e.data  = ex_wen_i ? ex_wdata_i : (lsu_valid_i ? lsu_data_i : 32'd0);
      e.ready = g;
      e.stall = (id_rs1_i != 0 && m_pend[id_rs1_i]) || (id_rs2_i != 0 && m_pend[id_rs2_i])
                || (id_rd_i != 0 && m_pend[id_rd_i]);
      e.hold  = m_hold;
      e.pend  = m_pend;
    end
    exp_q.push_back(e);
    @(negedge clk);
    obs_wen = reg_wen_o; obs_addr = reg_waddr_o; obs_data = reg_wdata_o;
    obs_ready = lsu_ready_o; obs_stall = stall_o; obs_hold = ex_hold_o; obs_pend = pending_o;
    got = exp_q.pop_front();
    checkOutput("reg_wen", {31'd0, obs_wen}, {31'd0, got.wen});
    checkOutput("reg_waddr", {27'd0, obs_addr}, {27'd0, got.addr});
    checkOutput("reg_wdata", obs_data, got.data);
    checkOutput("lsu_ready", {31'd0, obs_ready}, {31'd0, got.ready});
    checkOutput("stall", {31'd0, obs_stall}, {31'd0, got.stall});
    checkOutput("ex_hold", {31'd0, obs_hold}, {31'd0, got.hold});
    checkOutput("pending", obs_pend, got.pend);
    @(posedge clk);
    if (!rst) begin
      m_pend = 0; m_run = 0; m_hold = 0; m_blocked = 0;
    end else begin
      m_blocked = lsu_valid_i && !g;
      if (m_hold && g) m_hold = 0;
      m_run = m_blocked ? m_run + 1 : 0;
      if (m_run == StarveMax) m_hold = 1;
      if (g && lsu_rd_i != 0) m_pend[lsu_rd_i] = 0;
      if (ld_issue_i && ld_issue_rd_i != 0) m_pend[ld_issue_rd_i] = 1;
    end
    cyc++;
    #1;
  endtask

  initial begin
    rst = 0;
    clearInputs();
    @(posedge clk); #1;

    // Reset state with inputs active: everything reads zero.
    ex_wen_i = 1; ex_waddr_i = 5'd3; ex_wdata_i = 32'h55; ld_issue_i = 1; ld_issue_rd_i = 5'd4;
    applyStimulus();
    applyStimulus();
    rst = 1;
    clearInputs();
    applyStimulus();

    // EX and LSU collide: EX first, LSU on the next free cycle.
    $display("[TB] EX/LSU conflict");
    ex_wen_i = 1; ex_waddr_i = 5'd5; ex_wdata_i = 32'h11;
    lsu_valid_i = 1; lsu_rd_i = 5'd6; lsu_data_i = 32'hAA;
    applyStimulus();
    checkOutput("conflict_ex_addr", {27'd0, obs_addr}, 32'd5);
    checkOutput("conflict_ex_data", obs_data, 32'h11);
    checkOutput("conflict_ready0", {31'd0, obs_ready}, 32'd0);
    ex_wen_i = 0;
    applyStimulus();
    checkOutput("conflict_lsu_addr", {27'd0, obs_addr}, 32'd6);
    checkOutput("conflict_lsu_data", obs_data, 32'hAA);
    checkOutput("conflict_ready1", {31'd0, obs_ready}, 32'd1);
    clearInputs();

    // Load-use stall on x7 until the cycle after its grant.
    $display("[TB] load-use stall");
    ld_issue_i = 1; ld_issue_rd_i = 5'd7; id_rs2_i = 5'd7;
    applyStimulus();
    checkOutput("ldu_issue_cycle", {31'd0, obs_stall}, 32'd0);
    ld_issue_i = 0;
    applyStimulus();
    checkOutput("ldu_stall_n1", {31'd0, obs_stall}, 32'd1);
    applyStimulus();
    lsu_valid_i = 1; lsu_rd_i = 5'd7; lsu_data_i = 32'h7777;
    applyStimulus();
    checkOutput("ldu_grant_cycle", {31'd0, obs_stall}, 32'd1);
    lsu_valid_i = 0;
    applyStimulus();
    checkOutput("ldu_released", {31'd0, obs_stall}, 32'd0);
    clearInputs();

    // Simultaneous set and clear of x9: set wins.
    $display("[TB] simultaneous set/clear");
    ld_issue_i = 1; ld_issue_rd_i = 5'd9;
    applyStimulus();
    lsu_valid_i = 1; lsu_rd_i = 5'd9; lsu_data_i = 32'h99;
    applyStimulus();
    clearInputs();
    applyStimulus();
    checkOutput("setclr_x9", {31'd0, obs_pend[9]}, 32'd1);
    lsu_valid_i = 1; lsu_rd_i = 5'd9; lsu_data_i = 32'h9A;
    applyStimulus();
    clearInputs();
    applyStimulus();
    checkOutput("setclr_drained", obs_pend, 32'd0);

    // Starvation: hold in the 5th blocked cycle, released after the grant.
    $display("[TB] starvation");
    ex_wen_i = 1; ex_waddr_i = 5'd2; ex_wdata_i = 32'h22;
    lsu_valid_i = 1; lsu_rd_i = 5'd3; lsu_data_i = 32'h33;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus();
      checkOutput($sformatf("starve_hold_c%0d", i), {31'd0, obs_hold}, (i == 5) ? 32'd1 : 32'd0);
    end
    ex_wen_i = 0;
    applyStimulus();
    checkOutput("starve_grant", {31'd0, obs_ready}, 32'd1);
    clearInputs();
    applyStimulus();
    checkOutput("starve_released", {31'd0, obs_hold}, 32'd0);

    // x0 is never tracked and never stalls.
    $display("[TB] x0 handling");
    ld_issue_i = 1; ld_issue_rd_i = 5'd0;
    applyStimulus();
    ld_issue_i = 0; id_rs1_i = 5'd0;
    applyStimulus();
    checkOutput("x0_pending", obs_pend, 32'd0);
    checkOutput("x0_stall", {31'd0, obs_stall}, 32'd0);
    clearInputs();

    // Mid-operation reset with x7/x10 pending and the FSM in HOLD.
    $display("[TB] mid-operation reset");
    ld_issue_i = 1; ld_issue_rd_i = 5'd7;
    applyStimulus();
    ld_issue_rd_i = 5'd10;
    applyStimulus();
    ld_issue_i = 0;
    ex_wen_i = 1; ex_waddr_i = 5'd1; ex_wdata_i = 32'h1;
    lsu_valid_i = 1; lsu_rd_i = 5'd3; lsu_data_i = 32'h3;
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("mid_pending", obs_pend, 32'h0000_0480);
    checkOutput("mid_hold", {31'd0, obs_hold}, 32'd1);
    rst = 0; id_rs1_i = 5'd7;
    applyStimulus();
    checkOutput("rst_outputs", {obs_wen, obs_ready, obs_stall, obs_hold}, 32'd0);
    checkOutput("rst_pending", obs_pend, 32'd0);
    rst = 1;
    clearInputs();
    id_rs1_i = 5'd7; id_rs2_i = 5'd10;
    applyStimulus();
    checkOutput("post_rst_pending", obs_pend, 32'd0);
    checkOutput("post_rst_idle", {31'd0, obs_hold}, 32'd0);
    checkOutput("post_rst_stall", {31'd0, obs_stall}, 32'd0);

    // Randomised traffic; the LSU keeps its request stable while blocked.
    $display("[TB] random traffic");
    for (int i = 0; i < 200; i++) begin
      ex_wen_i = ($urandom_range(0, 2) == 0);
      ex_waddr_i = 5'($urandom); ex_wdata_i = $urandom;
      ld_issue_i = ($urandom_range(0, 3) == 0); ld_issue_rd_i = 5'($urandom);
      if (!m_blocked) begin
        lsu_valid_i = ($urandom_range(0, 1) == 1);
        lsu_rd_i = 5'($urandom); lsu_data_i = $urandom;
      end
      id_rs1_i = 5'($urandom); id_rs2_i = 5'($urandom); id_rd_i = 5'($urandom);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regs_wb_sched.md
# regs_wb_sched

Write-port scheduler for the 32x32 integer register file. Arbitrates the single register-file write port between the single-cycle EX result and late-returning load data from the LSU. Tracks outstanding load destinations in a scoreboard and raises a stall to ID on RAW/WAW hazards. Sits between EX/LSU and `regs`. It drives `regs`' write port combinationally, so `regs`' same-cycle forwarding stays valid.

## Interface
Parameters:
- `STARVE_MAX`, 4: consecutive blocked LSU cycles before EX is held off (range 1..15).

Ports:
- `clk`  in  1  single clock, all state on posedge.
- `rst`  in  1  synchronous, active-low reset.
- `ex_wen_i`  in  1  EX write request.
- `ex_waddr_i`  in  5  EX destination register.
- `ex_wdata_i`  in  32  EX write data.
- `ld_issue_i`  in  1  a load has been issued to memory this cycle.
- `ld_issue_rd_i`  in  5  destination register of that load.
- `lsu_valid_i`  in  1  LSU has load data ready to write back.
- `lsu_rd_i`  in  5  LSU destination register.
- `lsu_data_i`  in  32  LSU load data.
- `lsu_ready_o`  out  1  LSU write granted this cycle.
- `id_rs1_i`, `id_rs2_i`, `id_rd_i`  in  5 each  register indices of the instruction in ID.
- `stall_o`  out  1  ID must hold.
- `ex_hold_o`  out  1  EX must not present a write next cycle.
- `reg_wen_o`  out  1  to `regs.reg_wen`.
- `reg_waddr_o`  out  5  to `regs.reg_waddr_i`.
- `reg_wdata_o`  out  32  to `regs.reg_wdata_i`.
- `pending_o`  out  32  scoreboard, bit n set means x_n awaits load data.

## Operation
- **Arbitration (combinational):**
  - EX has priority. If `ex_wen_i`, the port carries the EX write and `lsu_ready_o`=0.
  - Otherwise, if `lsu_valid_i`, the port carries the LSU write and `lsu_ready_o`=1.
  - Otherwise `reg_wen_o`=0, and address/data are 0.
- **LSU handshake:**
  - The LSU holds `lsu_rd_i`/`lsu_data_i` stable while `lsu_valid_i` && !`lsu_ready_o`.
  - The transfer completes on a cycle with both high.
- **Writes to x0:** passed through unchanged; `regs` discards them. They never set or clear the scoreboard.
- **Scoreboard `pending` (32 flops, bit 0 hard 0):**
  - Set: bit `ld_issue_rd_i` when `ld_issue_i`.
  - Clear: bit `lsu_rd_i` on an LSU grant.
  - Same index set and cleared in one cycle: set wins, because a new load is outstanding.
- **Stall:** `stall_o` = `pending[id_rs1_i]` | `pending[id_rs2_i]` | `pending[id_rd_i]`, with x0 indices masked. This is combinational on the current `pending`.
- **Starvation counter `blk_cnt` (4 bits):**
  - Increments each cycle `lsu_valid_i` && !`lsu_ready_o`, saturating at `STARVE_MAX`.
  - Clears on an LSU grant or when `lsu_valid_i`=0.
- **Hold FSM, states IDLE and HOLD:**
  - IDLE -> HOLD when `blk_cnt` == `STARVE_MAX`.
  - HOLD -> IDLE on an LSU grant.
  - `ex_hold_o` = (state==HOLD).
  - If EX still asserts `ex_wen_i` in HOLD, EX still wins; the FSM stays in HOLD.

## Timing
- Write port, `lsu_ready_o` and `stall_o`: zero-latency combinational paths.
- `pending` is updated at the clock edge.
  - A load issued in cycle N stalls a dependent ID instruction from cycle N+1.
  - A grant in cycle N releases the stall in cycle N+1.
- `ex_hold_o` rises one cycle after `blk_cnt` reaches `STARVE_MAX`.
  - Worst-case LSU wait under continuous EX traffic: `STARVE_MAX`+2 cycles.
- **Reset (`rst`=0 at posedge):**
  - `pending`=0, `blk_cnt`=0, FSM=IDLE.
  - While `rst`=0 all outputs are forced low: `reg_wen_o`, `lsu_ready_o`, `stall_o`, `ex_hold_o`, `pending_o`; address/data=0.
  - Reset mid-operation drops all outstanding loads. The LSU is reset on the same signal.

## Structure
- Shared package/header holds `ZeroWord` (32'h0), `ZeroReg` (5'h0), and the FSM state encodings IDLE=1'b0, HOLD=1'b1.
- One natural sub-module, `wb_scoreboard`. It contains the pending register file, set/clear logic and the three-port hazard lookup.
- Arbitration, counter and FSM stay in the top.

## Test plan
- **EX/LSU conflict:**
  - Stimulus: `ex_wen_i`=1, x5=0x11, with `lsu_valid_i`=1, x6=0xAA.
  - Required: port writes x5 with `lsu_ready_o`=0. Next cycle with `ex_wen_i`=0: port writes x6=0xAA with `lsu_ready_o`=1.
- **Load-use stall:**
  - Stimulus: `ld_issue_i` with rd=7, then `id_rs2_i`=7.
  - Required: `stall_o`=1 from the next cycle until the cycle after the LSU grant for x7, then 0.
- **Simultaneous set/clear:**
  - Stimulus: LSU grant on x9 in the same cycle as `ld_issue_i` rd=9.
  - Required: `pending_o[9]` stays 1.
- **Starvation** (`STARVE_MAX`=4):
  - Stimulus: continuous `ex_wen_i` with LSU valid.
  - Required: `ex_hold_o`=1 in the 5th blocked cycle. Once EX drops `ex_wen_i`, the LSU is granted and `ex_hold_o`=0 next cycle.
- **x0 handling:**
  - Stimulus: `ld_issue_i` rd=0, then `id_rs1_i`=0.
  - Required: `pending_o`=0 and `stall_o`=0.
- **Mid-operation reset:**
  - Stimulus: `pending_o`=0x0000_0480 with FSM in HOLD, then `rst`=0 for one cycle.
  - Required: all outputs 0 during reset, `pending_o`=0, FSM=IDLE afterwards.
